// File: rtl/csa_chunk_add_sched.sv
// csa_chunk_add_sched
//   Shares one combinational CHUNK-bit adder core between two requesters.
//   An accepted W-bit addition (W = CHUNK*NCHUNK) is executed chunk-serially,
//   LSB chunk first, one chunk per clock, with each chunk's carry-out fed back
//   as the next chunk's carry-in. The result is held until the consumer
//   accepts it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_ci   requester N operands and carry-in
//   add_x, add_y, add_ci      drive to the shared adder core (zero unless running)
//   add_s                     adder core sum, bit CHUNK is the carry-out
//   res_valid / res_ready     result handshake
//   res_sum, res_co, res_id   W-bit sum, final carry-out, issuing requester
//   busy                      an operation is running or waiting to be consumed
module csa_chunk_add_sched #(
    parameter int CHUNK  = 12,
    parameter int NCHUNK = 4,
    localparam int W     = CHUNK * NCHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req0_ci,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic             req1_ci,
    output logic [CHUNK-1:0] add_x,
    output logic [CHUNK-1:0] add_y,
    output logic             add_ci,
    input  logic [CHUNK:0]   add_s,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_sum,
    output logic             res_co,
    output logic             res_id,
    output logic             busy
);

    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q;
    logic            id_q;
    logic            carry_q;
    logic            co_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;

    logic            gnt;
    logic            accept;
    logic            last_chunk;

    // Grant follows valids only: a lone requester wins, a tie goes to rr_q.
    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = rr_q;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
    end

    assign accept     = req0_ready || req1_ready;
    assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)     state_d = RUN;
            RUN:  if (last_chunk) state_d = DONE;
            DONE: if (res_ready)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Output logic. Ready and result-valid are held low while reset is
    // asserted so no handshake can complete in a reset cycle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        add_x      = '0;
        add_y      = '0;
        add_ci     = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    req0_ready = req0_valid && !gnt;
                    req1_ready = req1_valid && gnt;
                end
            end
            RUN: begin
                add_x  = a_q[int'(idx_q)*CHUNK +: CHUNK];
                add_y  = b_q[int'(idx_q)*CHUNK +: CHUNK];
                add_ci = carry_q;
                busy   = 1'b1;
            end
            DONE: begin
                res_valid = !rst;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, chunk sequencing and result assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            if (state_q == IDLE && accept) begin
                a_q     <= gnt ? req1_a : req0_a;
                b_q     <= gnt ? req1_b : req0_b;
                carry_q <= gnt ? req1_ci : req0_ci;
                id_q    <= gnt;
                rr_q    <= ~gnt;
                idx_q   <= '0;
            end
            if (state_q == RUN) begin
                sum_q[int'(idx_q)*CHUNK +: CHUNK] <= add_s[CHUNK-1:0];
                carry_q                            <= add_s[CHUNK];
                if (last_chunk) begin
                    co_q <= add_s[CHUNK];
                end else begin
                    idx_q <= idx_q + IDXW'(1);
                end
            end
        end
    end

    assign res_sum = sum_q;
    assign res_co  = co_q;
    assign res_id  = id_q;

endmodule

// File: tb/tb_csa_chunk_add_sched.sv
// tb_csa_chunk_add_sched
//   Self-checking bench for csa_chunk_add_sched with a behavioural adder core.
//   Accepted operations are pushed to a scoreboard with their A+B+ci result;
//   a monitor process checks the adder drive chunk by chunk and pops/compares
//   every delivered result.
module tb_csa_chunk_add_sched;

    localparam int CHUNK  = 12;
    localparam int NCHUNK = 4;
    localparam int W      = CHUNK * NCHUNK;

    typedef struct packed {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
    } op_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_ci;
    logic [W-1:0]     req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_ci;
    logic [W-1:0]     req1_a, req1_b;
    logic [CHUNK-1:0] add_x, add_y;
    logic             add_ci;
    logic [CHUNK:0]   add_s;
    logic             res_valid, res_ready, res_co, res_id, busy;
    logic [W-1:0]     res_sum;

    always #5 clk = ~clk;

    // Behavioural adder core
    assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{CHUNK{1'b0}}, add_ci};

    csa_chunk_add_sched #(.CHUNK(CHUNK), .NCHUNK(NCHUNK)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ci(req0_ci),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ci(req1_ci),
        .add_x(add_x), .add_y(add_y), .add_ci(add_ci), .add_s(add_s),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_co(res_co), .res_id(res_id), .busy(busy)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    op_t          sb[$];
    bit           inflight = 1'b0;
    int unsigned  acc_cyc  = 0;
    bit           rr_m     = 1'b0;
    bit           pend[2];
    logic [W-1:0] pa[2], pb[2];
    logic         pci[2];
    bit           rnd_mode = 1'b0;
    logic         rdy_dir  = 1'b1;
    int unsigned  n_acc = 0, n_res = 0, n_disc = 0;
    logic [W-1:0] last_sum;
    logic         last_co, last_id;
    int unsigned  acc_log[$], hs_log[$];
    bit           seen_ids[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] rand48();
        return {16'($urandom), $urandom};
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return rand48();
        endcase
    endfunction

    task automatic load(input int unsigned i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pci[i]  = ci;
    endtask

    task automatic do_accept(input bit id);
        if (req0_valid && req1_valid) chk("rr_grant", 64'(id), 64'(rr_m));
        sb.push_back('{id: id, a: pa[id], b: pb[id], ci: pci[id]});
        inflight = 1'b1;
        acc_cyc  = cyc;
        acc_log.push_back(cyc);
        rr_m     = !id;
        pend[id] = 1'b0;
        n_acc++;
    endtask

    // One clock: drive after posedge, evaluate the handshake at negedge.
    task automatic do_cycle();
        bit e0, e1;
        req0_valid = pend[0] && (!rnd_mode || $urandom_range(0, 99) < 70);
        req1_valid = pend[1] && (!rnd_mode || $urandom_range(0, 99) < 70);
        req0_a  = pend[0] ? pa[0] : rand48();
        req0_b  = pend[0] ? pb[0] : rand48();
        req0_ci = pend[0] ? pci[0] : 1'($urandom);
        req1_a  = pend[1] ? pa[1] : rand48();
        req1_b  = pend[1] ? pb[1] : rand48();
        req1_ci = pend[1] ? pci[1] : 1'($urandom);
        res_ready = rnd_mode ? ($urandom_range(0, 99) < 60) : rdy_dir;
        @(negedge clk);
        if (!rst) begin
            e0 = !inflight && req0_valid && (!req1_valid || !rr_m);
            e1 = !inflight && req1_valid && (!req0_valid || rr_m);
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
            chk("ready_excl", 64'(req0_ready && req1_ready), 64'(0));
            if (req0_valid && req0_ready)      do_accept(1'b0);
            else if (req1_valid && req1_ready) do_accept(1'b1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned n);
        rst = 1'b1;
        if (inflight) n_disc++;
        sb.delete();
        inflight = 1'b0;
        rr_m     = 1'b0;
        pend[0]  = 1'b0;
        pend[1]  = 1'b0;
        repeat (n) do_cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned maxc);
        int unsigned n = 0;
        while ((inflight || pend[0] || pend[1]) && n < maxc) begin
            do_cycle();
            n++;
        end
        chk("idle_timeout", 64'(inflight || pend[0] || pend[1]), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_res_sum"}, 64'(res_sum), 64'(0));
        chk({tag, "_res_co"}, 64'(res_co), 64'(0));
        chk({tag, "_res_id"}, 64'(res_id), 64'(0));
        chk({tag, "_add"}, 64'({add_x, add_y, add_ci}), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'(0));
    endtask

    // Monitor: checks adder drive per chunk and pops the scoreboard on results.
    always @(negedge clk) begin
        int unsigned k;
        op_t         op;
        logic [63:0] mk, cm, ex;
        #1;
        if (!rst) begin
            cm = (64'(1) << CHUNK) - 64'(1);
            if (inflight && sb.size() > 0 && cyc > acc_cyc && cyc <= acc_cyc + NCHUNK) begin
                k  = cyc - acc_cyc - 1;
                op = sb[0];
                mk = (64'(1) << (k * CHUNK)) - 64'(1);
                chk("add_x", 64'(add_x), (64'(op.a) >> (k * CHUNK)) & cm);
                chk("add_y", 64'(add_y), (64'(op.b) >> (k * CHUNK)) & cm);
                chk("add_ci", 64'(add_ci),
                    ((64'(op.a) & mk) + (64'(op.b) & mk) + 64'(op.ci)) >> (k * CHUNK));
                chk("run_res_valid", 64'(res_valid), 64'(0));
                chk("run_busy", 64'(busy), 64'(1));
            end else begin
                chk("idle_add", 64'({add_x, add_y, add_ci}), 64'(0));
                if (inflight && sb.size() > 0 && cyc > acc_cyc) begin
                    op = sb[0];
                    ex = 64'(op.a) + 64'(op.b) + 64'(op.ci);
                    chk("done_res_valid", 64'(res_valid), 64'(1));
                    chk("done_busy", 64'(busy), 64'(1));
                    chk("done_hold_sum", 64'({res_co, res_sum}), ex);
                end else begin
                    chk("idle_res_valid", 64'(res_valid), 64'(0));
                    chk("idle_busy", 64'(busy), 64'(0));
                end
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    op = sb.pop_front();
                    ex = 64'(op.a) + 64'(op.b) + 64'(op.ci);
                    chk("result_sum", 64'({res_co, res_sum}), ex);
                    chk("result_id", 64'(res_id), 64'(op.id));
                    last_sum = res_sum;
                    last_co  = res_co;
                    last_id  = res_id;
                    n_res++;
                    inflight = 1'b0;
                    hs_log.push_back(cyc);
                    seen_ids.push_back(res_id);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] s_snap;
        logic         co_snap, id_snap;
        int unsigned  n, start;

        pend[0] = 1'b0;
        pend[1] = 1'b0;
        rst       = 1'b1;
        res_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_ci = 1'b0;
        req1_a = '0; req1_b = '0; req1_ci = 1'b0;
        #1;

        // Reset with req0 already valid: ready stays low until reset releases.
        load(0, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0);
        repeat (3) do_cycle();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Carry ripple across all chunks
        wait_idle(50);
        chk("ripple_sum", 64'(last_sum), 64'(0));
        chk("ripple_co", 64'(last_co), 64'(1));
        chk("ripple_id", 64'(last_id), 64'(0));

        // Carry-in only, from requester 1
        load(1, 48'h1234_5678_9ABC, 48'h0, 1'b1);
        wait_idle(50);
        chk("cin_sum", 64'(last_sum), 64'h1234_5678_9ABD);
        chk("cin_co", 64'(last_co), 64'(0));
        chk("cin_id", 64'(last_id), 64'(1));

        // Contention from reset release, then a third req0 while req1 waits
        do_reset(2);
        seen_ids.delete();
        acc_log.delete();
        hs_log.delete();
        load(0, 48'h0000_1111_2222, 48'h0000_0333_0444, 1'b0);
        load(1, 48'h0AAA_BBBB_CCCC, 48'h0111_0000_0001, 1'b1);
        n = 0;
        while (acc_log.size() == 0 && n < 10) begin
            do_cycle();
            n++;
        end
        load(0, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b1);
        wait_idle(100);
        chk("order_count", 64'(seen_ids.size()), 64'(3));
        if (seen_ids.size() == 3) begin
            chk("order_first", 64'(seen_ids[0]), 64'(0));
            chk("order_second", 64'(seen_ids[1]), 64'(1));
            chk("order_third", 64'(seen_ids[2]), 64'(0));
        end
        if (acc_log.size() == 3 && hs_log.size() >= 2) begin
            chk("reaccept_gap1", 64'(acc_log[1]), 64'(hs_log[0] + 1));
            chk("reaccept_gap2", 64'(acc_log[2]), 64'(hs_log[1] + 1));
        end

        // Back-pressure in DONE with the other requester waiting
        rdy_dir = 1'b0;
        load(0, rand48(), rand48(), 1'b1);
        n = 0;
        while (!res_valid && n < 20) begin
            do_cycle();
            n++;
        end
        chk("bp_reach_done", 64'(res_valid), 64'(1));
        s_snap  = res_sum;
        co_snap = res_co;
        id_snap = res_id;
        load(1, rand48(), rand48(), 1'b0);
        repeat (10) begin
            do_cycle();
            chk("bp_valid", 64'(res_valid), 64'(1));
            chk("bp_stable", 64'({res_id, res_co, res_sum}), 64'({id_snap, co_snap, s_snap}));
            chk("bp_ready_low", 64'({req0_ready, req1_ready}), 64'(0));
        end
        rdy_dir = 1'b1;
        do_cycle();
        do_cycle();
        chk("bp_next_accept", 64'(acc_log[$]), 64'(hs_log[$] + 1));
        wait_idle(50);

        // Reset while chunk index 2 is being added
        load(0, 48'h0FFF_0FFF_0FFF, 48'h0001_0001_0001, 1'b1);
        n = 0;
        while (!inflight && n < 10) begin
            do_cycle();
            n++;
        end
        do_cycle();
        do_cycle();
        chk("midrun_busy", 64'(busy), 64'(1));
        do_reset(1);
        chk_reset_outputs("midrun");
        load(0, 48'h0000_0000_0FFF, 48'h0000_0000_0001, 1'b0);
        wait_idle(50);
        chk("post_reset_sum", 64'(last_sum), 64'h1000);
        chk("post_reset_co", 64'(last_co), 64'(0));

        // Random regression
        rnd_mode = 1'b1;
        start = n_acc;
        n = 0;
        while (n_acc - start < 1000 && n < 40000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) load(i, rand_op(), rand_op(), 1'($urandom));
            end
            do_cycle();
            n++;
        end
        chk("rand_ops_done", 64'(n_acc - start >= 1000), 64'(1));
        wait_idle(2000);
        chk("no_loss", 64'(n_res + n_disc), 64'(n_acc));
        chk("sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csa_chunk_add_sched.md
Name: csa_chunk_add_sched

Overview:
- Sequencer and arbiter that shares one combinational CHUNK-bit carry-select adder core (X, Y, Cin -> S[CHUNK:0]) between two requesters.
- Performs W = CHUNK*NCHUNK-bit additions chunk-serially, one chunk per clock, LSB chunk first, chaining each chunk's carry-out into the next chunk's carry-in.
- Sits between the requesters and the adder instance; holds the result until the consumer accepts it.

Parameters:
- CHUNK, 12, adder core operand width in bits.
- NCHUNK, 4, chunks per operation; W = CHUNK*NCHUNK (48 by default).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  W  operand A
- req0_b  in  W  operand B
- req0_ci  in  1  carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_ci  same as requester 0, for requester 1
- add_x  out  CHUNK  adder core operand X
- add_y  out  CHUNK  adder core operand Y
- add_ci  out  1  adder core carry-in
- add_s  in  CHUNK+1  adder core sum; bit CHUNK is carry-out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  W  W-bit sum
- res_co  out  1  final carry-out
- res_id  out  1  requester that issued the operation
- busy  out  1  high in RUN or DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state IDLE; rr_ptr=0 (requester 0 preferred); idx=0; carry=0.
- Outputs after reset: res_valid=0, res_sum=0, res_co=0, res_id=0, add_x=0, add_y=0, add_ci=0, busy=0, req*_ready=0 until the first cycle out of reset.

- States: IDLE, RUN, DONE.

- IDLE, grant (combinational):
  - Only req0 valid: grant 0.
  - Only req1 valid: grant 1.
  - Both valid: grant rr_ptr.
  - reqN_ready = IDLE & grant==N; at most one ready high per cycle.
  - ready must not depend on the same requester's ready, only on its valid.
- IDLE, on accept (valid & ready):
  - Latch A, B, ci and id.
  - carry<=ci, idx<=0.
  - rr_ptr <= ~granted id.
  - Go to RUN.
- RUN, each cycle:
  - add_x = A[idx*CHUNK +: CHUNK], add_y = B[idx*CHUNK +: CHUNK], add_ci = carry.
  - Clock edge: sum chunk idx <= add_s[CHUNK-1:0]; carry <= add_s[CHUNK].
  - idx==NCHUNK-1: res_co <= add_s[CHUNK], go to DONE; otherwise idx<=idx+1.
- Adder drive outside RUN: add_x, add_y and add_ci are driven 0 in IDLE and DONE.
- DONE:
  - res_valid=1; res_sum, res_co, res_id held stable.
  - On res_valid & res_ready: go to IDLE.
  - No accept in the same cycle; ready rises the following cycle.
- Latency:
  - Accept at cycle T gives res_valid at T+NCHUNK+1.
  - Minimum issue interval is NCHUNK+2 cycles.
- res_sum: chunks not yet written during RUN hold the previous operation's values. res_sum is only defined while res_valid=1.
- Requester inputs: ignored outside the accept cycle; operands may change after acceptance.
- Reset mid-RUN or mid-DONE: operation discarded, all outputs return to reset values next cycle, no result emitted.
- res_ready asserted while not DONE: ignored.
- Arithmetic: res_co:res_sum = A + B + ci exactly, modulo 2^(W+1).

Test Plan:
- Single op, carry ripple: req0 A=0xFFFFFFFFFFFF, B=0x000000000001, ci=0, res_ready=1 -> add_x sequence 0xFFF x4, add_ci sequence 0,1,1,1; res_sum=0, res_co=1, res_id=0; res_valid exactly NCHUNK+1=5 cycles after accept.
- Carry-in only: req1 A=0x123456789ABC, B=0, ci=1 -> res_sum=0x123456789ABD, res_co=0, res_id=1.
- Contention: req0 and req1 both valid from reset release with distinct operands -> req0 served first, req1 accepted on the first IDLE cycle after req0's result handshake. A third back-to-back req0 while req1 is still valid -> req1 then req0 order holds (round-robin).
- Back-pressure: res_ready=0 for 10 cycles in DONE -> res_valid stays 1, res_sum/res_co/res_id stable, both ready low, add_x/add_y/add_ci = 0. Then res_ready=1 -> IDLE next cycle, new accept possible the cycle after.
- Reset mid-RUN: assert rst when idx=2 -> next cycle all outputs at reset values, no res_valid. The following op A=0x000000000FFF, B=0x000000000001 -> res_sum=0x000000001000, res_co=0, proving carry was cleared.
- Random regression: 1000 random A, B, ci with random valid and res_ready on both requesters -> every result equals the reference model A+B+ci with the correct res_id; no request lost or duplicated; ready never high for both requesters in one cycle.
